// File: rtl/clk_div_gen_pkg.sv
// Shared types and defaults for the clk_div_gen clock divider/reset sequencer.
package clk_div_gen_pkg;

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StCount    = 2'd1,
    StRelease  = 2'd2,
    StRun      = 2'd3
  } clk_div_state_e;

  localparam int unsigned DefaultDiv = 8;
  localparam int unsigned LockCycles = 16;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: shadowed ratio with glitch-free update, clock-enable pulse and 50% clock.
module clk_div_ch
  import clk_div_gen_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = DefaultDiv
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             active_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load_i,
  output logic             clk_en_o,
  output logic             clk_div_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] pending_q, pending_d;
  logic [DIV_W-1:0] n_eff;
  logic             wrap;
  logic             clk_en_q, clk_en_d;
  logic             clk_div_q, clk_div_d;

  always_comb begin
    n_eff     = (shadow_q == '0) ? DIV_W'(1) : shadow_q;
    wrap      = (cnt_q >= n_eff - DIV_W'(1));
    pending_d = div_load_i ? div_i : pending_q;
    shadow_d  = shadow_q;
    cnt_d     = '0;
    clk_en_d  = 1'b0;
    clk_div_d = 1'b0;
    if (active_i) begin
      cnt_d     = wrap ? '0 : cnt_q + DIV_W'(1);
      clk_en_d  = wrap;
      clk_div_d = clk_div_q ^ wrap;
      // Ratio only changes on a wrap so no half-period is ever shortened.
      if (wrap) shadow_d = pending_q;
    end else begin
      shadow_d = pending_d;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      shadow_q  <= DIV_W'(DEFAULT_DIV);
      pending_q <= DIV_W'(DEFAULT_DIV);
      clk_en_q  <= 1'b0;
      clk_div_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_en_q  <= clk_en_d;
      clk_div_q <= clk_div_d;
    end
  end

  assign clk_en_o  = clk_en_q;
  assign clk_div_o = clk_div_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider with PLL-lock gated domain reset release.
// Define CLK_DIV_GEN_RST_SEQ_EN to release channel resets one per cycle instead of all at once.
module clk_div_gen
  import clk_div_gen_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned LOCK_CYCLES = LockCycles,
  parameter int unsigned DEFAULT_DIV = DefaultDiv
) (
  input  logic                    clk_in,
  input  logic                    reset_n,
  input  logic                    pll_locked_in,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic [NUM_CH-1:0]       div_load_i,
  input  logic [NUM_CH-1:0]       ch_en_i,
  output logic [NUM_CH-1:0]       clk_en_o,
  output logic [NUM_CH-1:0]       clk_div_o,
  output logic [NUM_CH-1:0]       rst_n_o,
  output logic                    ready_o
);

  localparam int unsigned LcW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [1:0]        sync_q;
  logic              lock_s;
  clk_div_state_e    state_q, state_d;
  logic [LcW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;

`ifdef CLK_DIV_GEN_RST_SEQ_EN
  localparam int unsigned RelW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  logic [RelW-1:0] rel_q, rel_d;
`endif

  // pll_locked_in is asynchronous to clk_in
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], pll_locked_in};
  end
  assign lock_s = sync_q[1];

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StWaitLock;
      lock_cnt_q <= '0;
      rst_n_q    <= '0;
`ifdef CLK_DIV_GEN_RST_SEQ_EN
      rel_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rst_n_q    <= rst_n_d;
`ifdef CLK_DIV_GEN_RST_SEQ_EN
      rel_q      <= rel_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    rst_n_d    = rst_n_q;
`ifdef CLK_DIV_GEN_RST_SEQ_EN
    rel_d      = rel_q;
`endif
    case (state_q)
      StWaitLock: begin
        rst_n_d    = '0;
        lock_cnt_d = '0;
        if (lock_s) state_d = StCount;
      end
      StCount: begin
        if (!lock_s) begin
          state_d    = StWaitLock;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LcW'(LOCK_CYCLES - 1)) begin
`ifdef CLK_DIV_GEN_RST_SEQ_EN
          state_d = StRelease;
          rel_d   = '0;
`else
          state_d = StRun;
          rst_n_d = '1;
`endif
        end else begin
          lock_cnt_d = lock_cnt_q + LcW'(1);
        end
      end
      StRelease: begin
`ifdef CLK_DIV_GEN_RST_SEQ_EN
        if (!lock_s) begin
          state_d = StWaitLock;
          rst_n_d = '0;
        end else begin
          rst_n_d[rel_q] = 1'b1;
          if (rel_q == RelW'(NUM_CH - 1)) state_d = StRun;
          else                            rel_d   = rel_q + RelW'(1);
        end
`else
        state_d = StWaitLock;
        rst_n_d = '0;
`endif
      end
      StRun: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          rst_n_d = '0;
        end
      end
      default: begin
        state_d = StWaitLock;
        rst_n_d = '0;
      end
    endcase
  end

  always_comb begin
    ready_o = (state_q == StRun);
  end

  assign rst_n_o = rst_n_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_in    (clk_in),
      .reset_n   (reset_n),
      .active_i  (ch_en_i[i] & rst_n_q[i]),
      .div_i     (div_i[i*DIV_W +: DIV_W]),
      .div_load_i(div_load_i[i]),
      .clk_en_o  (clk_en_o[i]),
      .clk_div_o (clk_div_o[i])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed self-checking bench for clk_div_gen (defaults: 4 channels, 8-bit ratios, 16 lock cycles).
module tb_clk_div_gen;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        pll_locked_in;
  logic [31:0] div_i;
  logic [3:0]  div_load_i;
  logic [3:0]  ch_en_i;
  logic [3:0]  clk_en_o;
  logic [3:0]  clk_div_o;
  logic [3:0]  rst_n_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  clk_div_gen dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .pll_locked_in(pll_locked_in),
    .div_i        (div_i),
    .div_load_i   (div_load_i),
    .ch_en_i      (ch_en_i),
    .clk_en_o     (clk_en_o),
    .clk_div_o    (clk_div_o),
    .rst_n_o      (rst_n_o),
    .ready_o      (ready_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // base = edge (counted from now) at which the lock counter completes.
  task automatic lock_seq(input int base, input string tag);
    logic [3:0] exp_rst;
    logic       exp_rdy;
    for (int e = 1; e <= base + 5; e++) begin
      step(1);
`ifdef CLK_DIV_GEN_RST_SEQ_EN
      if (e <= base)          exp_rst = 4'h0;
      else if (e >= base + 4) exp_rst = 4'hF;
      else                    exp_rst = 4'((1 << (e - base)) - 1);
      exp_rdy = (e >= base + 4);
`else
      exp_rst = (e >= base) ? 4'hF : 4'h0;
      exp_rdy = (e >= base);
`endif
      check({tag, "_rst"}, 32'(rst_n_o), 32'(exp_rst));
      check({tag, "_rdy"}, 32'(ready_o), 32'(exp_rdy));
    end
  endtask

  task automatic set_ratio(input int ch, input logic [7:0] val);
    div_i[ch*8 +: 8] = val;
    div_load_i[ch]   = 1'b1;
    step(1);
    div_load_i[ch]   = 1'b0;
  endtask

  // Enables channel ch, then compares clk_en/clk_div against a pulse mask (bit e = pulse after edge e).
  task automatic run_pattern(input int ch, input int edges, input logic [31:0] mask,
                             input int load_at, input logic [7:0] load_val, input string tag);
    logic exp_div;
    exp_div     = 1'b0;
    ch_en_i[ch] = 1'b1;
    for (int e = 1; e <= edges; e++) begin
      step(1);
      div_load_i[ch] = 1'b0;
      if (mask[e]) exp_div = ~exp_div;
      check({tag, "_en"}, 32'(clk_en_o[ch]), 32'(mask[e]));
      check({tag, "_div"}, 32'(clk_div_o[ch]), 32'(exp_div));
      if (e == load_at) begin
        div_i[ch*8 +: 8] = load_val;
        div_load_i[ch]   = 1'b1;
      end
    end
    ch_en_i[ch] = 1'b0;
    step(1);
    check({tag, "_off_en"}, 32'(clk_en_o[ch]), 32'h0);
    check({tag, "_off_div"}, 32'(clk_div_o[ch]), 32'h0);
  endtask

  initial begin
    reset_n       = 1'b1;
    pll_locked_in = 1'b0;
    div_i         = '0;
    div_load_i    = '0;
    ch_en_i       = '0;
    #2 reset_n = 1'b0;
    #1;
    check("reset_rst", 32'(rst_n_o), 32'h0);
    check("reset_rdy", 32'(ready_o), 32'h0);
    check("reset_en", 32'(clk_en_o), 32'h0);
    check("reset_div", 32'(clk_div_o), 32'h0);

    step(1);
    reset_n       = 1'b1;
    pll_locked_in = 1'b1;
    lock_seq(19, "lock1");

    set_ratio(0, 8'd3);
    run_pattern(0, 12, 32'h0000_1248, 0, 8'd0, "n3");
    set_ratio(1, 8'd4);
    run_pattern(1, 18, 32'h0005_5110, 9, 8'd2, "n4to2");
    set_ratio(2, 8'd2);
    run_pattern(2, 13, 32'h0000_1254, 3, 8'd3, "ld_at_wrap");
    set_ratio(3, 8'd0);
    run_pattern(3, 11, 32'h0000_0FFE, 0, 8'd0, "n0");

    // One-cycle lock dropout while running.
    pll_locked_in = 1'b0;
    step(1);
    pll_locked_in = 1'b1;
    step(1);
    check("drop_rdy_held", 32'(ready_o), 32'h1);
    step(1);
    check("drop_rdy", 32'(ready_o), 32'h0);
    check("drop_rst", 32'(rst_n_o), 32'h0);
    lock_seq(17, "relock");

    // Asynchronous reset mid-count, between clock edges.
    ch_en_i[0] = 1'b1;
    step(4);
    check("pre_reset_div", 32'(clk_div_o[0]), 32'h1);
    #3 reset_n = 1'b0;
    #1;
    check("areset_rst", 32'(rst_n_o), 32'h0);
    check("areset_rdy", 32'(ready_o), 32'h0);
    check("areset_en", 32'(clk_en_o), 32'h0);
    check("areset_div", 32'(clk_div_o), 32'h0);
    ch_en_i = '0;
    #1 reset_n = 1'b1;
    lock_seq(19, "lock2");
    run_pattern(0, 17, 32'h0001_0100, 0, 8'd0, "n8_default");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
